// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Schedules three read requesters (dcache refill, uncached load, icache
// refill) onto a single AXI AR/R channel with one transaction outstanding.
// Fixed priority 0 > 1 > 2 is overridden by starvation aging on requesters
// 1 and 2. Requests that target a line still being written back are held
// off. Returned beats are routed to the owning requester, and burst-length
// violations raise a sticky error flag.
`timescale 1ns/1ps
module axi_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned LINE_BITS    = 5
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic [2:0]  req_valid,
    input  logic [95:0] req_addr,
    input  logic [23:0] req_len,
    input  logic [8:0]  req_size,
    output logic [2:0]  req_ack,
    output logic [2:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_last,
    input  logic        wb_busy,
    input  logic [31:0] wb_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nx;

    logic [31:0] addr_of [3];
    logic [7:0]  len_of  [3];
    logic [2:0]  size_of [3];
    logic [2:0]  blocked;
    logic [2:0]  eligible;

    // age[0] tracks requester 1, age[1] tracks requester 2
    logic [7:0]  age [2];

    logic [1:0]  sel;
    logic        any_elig;
    logic        grant;

    logic [1:0]  owner;
    logic [28:0] lat_addr;
    logic [7:0]  lat_len;
    logic [2:0]  lat_size;
    logic [7:0]  beat_cnt;

    // rid carries no routing information with a single outstanding read,
    // and the line-offset bits of wb_addr never take part in the hazard compare.
    logic        unused_in;
    assign unused_in = ^{rid, wb_addr[LINE_BITS-1:0]};

    // Split the packed request buses into per-requester views and flag hazards.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            addr_of[i]  = req_addr[32*i +: 32];
            len_of[i]   = req_len[8*i +: 8];
            size_of[i]  = req_size[3*i +: 3];
            blocked[i]  = wb_busy && (addr_of[i][31:LINE_BITS] == wb_addr[31:LINE_BITS]);
            eligible[i] = req_valid[i] && !blocked[i];
        end
    end

    // Pick the winner: starved 1, then starved 2, else fixed priority 0 > 1 > 2.
    always_comb begin
        sel      = 2'd0;
        any_elig = |eligible;
        if (eligible[1] && (age[0] == LIMIT)) begin
            sel = 2'd1;
        end else if (eligible[2] && (age[1] == LIMIT)) begin
            sel = 2'd2;
        end else if (eligible[0]) begin
            sel = 2'd0;
        end else if (eligible[1]) begin
            sel = 2'd1;
        end else if (eligible[2]) begin
            sel = 2'd2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-state channel outputs.
    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        req_ack    = 3'b000;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 3'b000;
        resp_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_elig) begin
                    grant        = 1'b1;
                    req_ack[sel] = 1'b1;
                    state_nx     = S_ADDR;
                end
            end
            S_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                rready     = 1'b1;
                resp_valid = rvalid ? (3'b001 << owner) : 3'b000;
                resp_last  = rlast;
                if (rvalid && rlast) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Latch the granted request, count returned beats and flag length errors.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            owner    <= '0;
            lat_addr <= '0;
            lat_len  <= '0;
            lat_size <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            if (grant) begin
                owner    <= sel;
                lat_addr <= addr_of[sel][28:0];
                lat_len  <= len_of[sel];
                lat_size <= size_of[sel];
                beat_cnt <= '0;
            end
            if ((state == S_DATA) && rvalid) begin
                // Early rlast, or the expected last beat arriving without rlast.
                if (rlast != (beat_cnt == lat_len)) begin
                    len_err <= 1'b1;
                end
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    // Starvation aging for requesters 1 and 2; blocked requesters still age.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            age[0] <= '0;
            age[1] <= '0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (req_valid[k+1] && !req_ack[k+1]) begin
                    if (age[k] < LIMIT) begin
                        age[k] <= age[k] + 8'd1;
                    end
                end else begin
                    age[k] <= '0;
                end
            end
        end
    end

    assign arid      = {2'b00, owner};
    assign araddr    = {3'b000, lat_addr};
    assign arlen     = lat_len;
    assign arsize    = lat_size;
    assign arburst   = 2'b01;
    assign resp_data = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a transaction-level reference model of the
// scheduler kept in this file.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_p;
    logic [2:0]  req_valid;
    logic [95:0] req_addr;
    logic [23:0] req_len;
    logic [8:0]  req_size;
    logic [2:0]  req_ack;
    logic [2:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        wb_busy;
    logic [31:0] wb_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        len_err;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .LINE_BITS   (5)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_ack   (req_ack),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_last (resp_last),
        .wb_busy   (wb_busy),
        .wb_addr   (wb_addr),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .len_err   (len_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // requester agents
    bit          pend [3];
    bit          cool [3];
    logic [31:0] p_addr [3];
    logic [7:0]  p_len [3];
    logic [2:0]  p_size [3];

    // stimulus knobs
    bit auto_req, auto_wb, ar_rand, rv_rand, err_inj, rereq0;

    // AXI slave agent
    bit s_active;
    int s_nb, s_sent, s_force_nb;

    // reference model: one outstanding transaction
    bit          m_busy, m_ar_done, m_err;
    int          m_own, m_beats;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    int          m_age [3];

    logic [2:0]  e_ack;
    int          grants[$];
    int          beats0;

    function automatic void model_reset();
        m_busy = 0; m_ar_done = 0; m_err = 0;
        m_own = 0; m_beats = 0;
        m_addr = '0; m_len = '0; m_size = '0;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
    endfunction

    function automatic int seq();
        int v = 0;
        foreach (grants[i]) v = v * 10 + grants[i] + 1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        pend[i] = 1; p_addr[i] = a; p_len[i] = l; p_size[i] = s;
    endtask

    task automatic prepare();
        int k;
        if (rereq0 && !pend[0] && !cool[0]) set_req(0, 32'h0000_0100, 8'd0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            if (auto_req && !pend[i] && !cool[i] && $urandom_range(0, 99) < 30)
                set_req(i, 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31)),
                        8'($urandom_range(0, 5)), 3'($urandom_range(0, 2)));
            req_valid[i]        = pend[i];
            req_addr[32*i +: 32] = p_addr[i];
            req_len[8*i +: 8]    = p_len[i];
            req_size[3*i +: 3]   = p_size[i];
        end
        if (auto_wb) begin
            wb_busy = ($urandom_range(0, 99) < 40);
            k = $urandom_range(0, 2);
            if (pend[k] && $urandom_range(0, 1) == 1) wb_addr = p_addr[k] ^ 32'($urandom_range(0, 31));
            else wb_addr = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5);
        end
        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata   = $urandom;
        if (m_busy && m_ar_done) begin
            if (!s_active) begin
                s_active = 1; s_sent = 0; s_nb = int'(m_len) + 1;
                if (s_force_nb > 0) begin
                    s_nb = s_force_nb; s_force_nb = 0;
                end else if (err_inj && $urandom_range(0, 3) == 0) begin
                    s_nb = $urandom_range(1, int'(m_len) + 3);
                end
            end
            rvalid = rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            rlast  = rvalid && (s_sent == s_nb - 1);
            rid    = 4'(m_own);
        end else begin
            s_active = 0;
            rvalid = rv_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            rlast  = 1'($urandom_range(0, 1));
            rid    = 4'($urandom_range(0, 15));
        end
    endtask

    // Compare one cycle at the falling edge, then advance the model.
    task automatic step();
        logic [2:0]  elig;
        logic [2:0]  ev;
        logic [31:0] a;
        int          sel;
        bit          exp_ar, exp_rr;
        @(negedge clk);
        elig = '0;
        for (int i = 0; i < 3; i++) begin
            a = req_addr[32*i +: 32];
            if (req_valid[i] && !(wb_busy && a[31:5] == wb_addr[31:5])) elig[i] = 1'b1;
        end
        sel = -1;
        if (!m_busy) begin
            for (int i = 1; i <= 2; i++) if (sel < 0 && elig[i] && m_age[i] == int'(LIMIT)) sel = i;
            for (int i = 0; i < 3; i++) if (sel < 0 && elig[i]) sel = i;
        end
        e_ack  = (sel >= 0) ? 3'(1 << sel) : 3'b000;
        exp_ar = m_busy && !m_ar_done;
        exp_rr = m_busy && m_ar_done;
        ev     = (exp_rr && rvalid) ? 3'(1 << m_own) : 3'b000;

        check("req_ack",    32'(req_ack),    32'(e_ack));
        check("arvalid",    32'(arvalid),    32'(exp_ar));
        check("rready",     32'(rready),     32'(exp_rr));
        check("resp_valid", 32'(resp_valid), 32'(ev));
        check("resp_last",  32'(resp_last),  32'(exp_rr && rlast));
        check("arid",       32'(arid),       32'(m_own));
        check("araddr",     araddr,          m_addr & 32'h1FFF_FFFF);
        check("arlen",      32'(arlen),      32'(m_len));
        check("arsize",     32'(arsize),     32'(m_size));
        check("arburst",    32'(arburst),    32'h1);
        check("len_err",    32'(len_err),    32'(m_err));
        if (ev != 3'b000) check("resp_data", resp_data, rdata);

        for (int i = 0; i < 3; i++) if (req_ack[i]) grants.push_back(i);
        if (resp_valid[0]) beats0++;

        if (rst_p) begin
            model_reset();
        end else begin
            for (int i = 1; i <= 2; i++) begin
                if (req_valid[i] && !e_ack[i]) begin
                    if (m_age[i] < int'(LIMIT)) m_age[i]++;
                end else begin
                    m_age[i] = 0;
                end
            end
            if (sel >= 0) begin
                m_busy = 1; m_ar_done = 0; m_own = sel; m_beats = 0;
                m_addr = req_addr[32*sel +: 32];
                m_len  = req_len[8*sel +: 8];
                m_size = req_size[3*sel +: 3];
            end else if (exp_ar) begin
                if (arready) m_ar_done = 1;
            end else if (exp_rr && rvalid) begin
                if (rlast && m_beats != int'(m_len)) m_err = 1;
                if (!rlast && m_beats == int'(m_len)) m_err = 1;
                if (m_beats < 255) m_beats++;
                if (rlast) m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic post();
        for (int i = 0; i < 3; i++) begin
            cool[i] = e_ack[i];
            if (e_ack[i]) pend[i] = 0;
        end
        if (s_active && rvalid) s_sent++;
    endtask

    task automatic cyc();
        prepare();
        step();
        post();
    endtask

    function automatic bit quiet();
        return !m_busy && !pend[0] && !pend[1] && !pend[2];
    endfunction

    initial begin
        rst_p = 1; req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
        wb_busy = 0; wb_addr = '0; arready = 0; rid = '0; rdata = '0; rlast = 0; rvalid = 0;
        auto_req = 0; auto_wb = 0; ar_rand = 0; rv_rand = 0; err_inj = 0; rereq0 = 0;
        s_active = 0; s_nb = 0; s_sent = 0; s_force_nb = 0; beats0 = 0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; cool[i] = 0; p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_p = 0;

        check("rst_arvalid", 32'(arvalid), 32'h0);
        check("rst_rready",  32'(rready),  32'h0);
        check("rst_len_err", 32'(len_err), 32'h0);
        check("rst_araddr",  araddr,       32'h0);
        check("rst_arburst", 32'(arburst), 32'h1);

        // single dcache refill
        grants.delete(); beats0 = 0;
        set_req(0, 32'h8000_1040, 8'd7, 3'd2);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (quiet()) break;
        end
        check("t1_grant",   32'(seq()),   32'd1);
        check("t1_beats",   32'(beats0),  32'd8);
        check("t1_araddr",  araddr,       32'h0000_1040);
        check("t1_arlen",   32'(arlen),   32'd7);
        check("t1_arid",    32'(arid),    32'd0);
        check("t1_len_err", 32'(len_err), 32'd0);

        // all three at once
        grants.delete();
        set_req(0, 32'h0000_0100, 8'd1, 3'd2);
        set_req(1, 32'h0000_0200, 8'd1, 3'd2);
        set_req(2, 32'h0000_0300, 8'd1, 3'd2);
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (quiet()) break;
        end
        check("t2_order", 32'(seq()), 32'd123);

        // starvation: requester 0 keeps re-requesting, requester 2 waits
        grants.delete();
        set_req(2, 32'h0000_0700, 8'd0, 3'd2);
        rereq0 = 1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (pend[2] == 0) break;
        end
        rereq0 = 0;
        check("t3_order", 32'(seq()), 32'd113);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (quiet()) break;
        end

        // write-back hazard holds requester 0 off
        grants.delete();
        wb_busy = 1; wb_addr = 32'h0000_2000;
        set_req(0, 32'h0000_2014, 8'd1, 3'd2);
        set_req(2, 32'h0000_3000, 8'd1, 3'd2);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (!m_busy && !pend[2]) break;
        end
        repeat (3) cyc();
        check("t4_first", 32'(seq()), 32'd3);
        wb_busy = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (quiet()) break;
        end
        check("t4_order", 32'(seq()), 32'd31);

        // len 0 answered with two beats
        grants.delete();
        set_req(1, 32'h0000_4000, 8'd0, 3'd2);
        s_force_nb = 2;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (quiet()) break;
        end
        check("t5_len_err", 32'(len_err), 32'd1);
        repeat (3) cyc();
        check("t5_sticky",  32'(len_err), 32'd1);
        check("t5_idle_rr", 32'(rready),  32'd0);

        // reset in the middle of a burst
        set_req(0, 32'h0000_5000, 8'd7, 3'd2);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (s_active && s_sent >= 3) break;
        end
        check("t6_beats_seen", 32'(s_sent), 32'd3);
        rst_p = 1;
        cyc();
        rst_p = 0;
        check("t6_rready",  32'(rready),  32'd0);
        check("t6_arvalid", 32'(arvalid), 32'd0);
        check("t6_len_err", 32'(len_err), 32'd0);
        grants.delete();
        set_req(2, 32'h0000_6000, 8'd2, 3'd1);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (quiet()) break;
        end
        check("t6_regrant", 32'(seq()), 32'd3);
        check("t6_arlen",   32'(arlen), 32'd2);

        // randomized traffic with well-formed bursts
        auto_req = 1; auto_wb = 1; ar_rand = 1; rv_rand = 1;
        repeat (3000) cyc();

        // randomized traffic with malformed bursts mixed in
        err_inj = 1;
        repeat (1000) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
